skeygen_rs: RTL and testbench

Parametrised Twofish S-box key generator, successor to the fixed 128-bit `skeygen`. It computes the k = N/64 S-words S_i = RS · (m_8i … m_8i+7) over GF(2^8) for 128-, 192- or 256-bit keys, selected at run time. It processes one key byte per enabled clock and emits each word on a valid strobe. It also holds all words in a packed bank for the h-function/g-function datapath.

---
 rtl/skeygen_rs.sv | 151 +++++++++++++++
 tb/tb_skeygen_rs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skeygen_rs.sv
// Twofish S-box key generator: S_i = RS * (m_8i..m_8i+7) over GF(2^8)/0x14D for 128/192/256-bit keys.
// Build option SKEYGEN_REVERSE_EN: emit/store words in Twofish vector order (S_(k-1) first).
module skeygen_rs #(
  parameter int unsigned KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                s_valid,
  output logic [31:0]         s_word,
  output logic [1:0]          s_idx,
  output logic [127:0]        keys_out,
  output logic                done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

`ifdef SKEYGEN_REVERSE_EN
  localparam bit REVERSE = 1'b1;
`else
  localparam bit REVERSE = 1'b0;
`endif

  logic [0:0]          state_q, state_d;
  logic [KEY_BITS-1:0] key_q;
  logic [2:0]          k_q;
  logic [1:0]          cnt_q;
  logic [2:0]          j_q;
  logic [31:0]         acc_q;

  logic                accept_c, step_c, last_c;
  logic [1:0]          widx_c;
  logic [7:0]          byte_c;
  logic [31:0]         acc_next_c;

  // GF(2^8) multiply, reduction polynomial x^8+x^6+x^3+x^2+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h4D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rs_coef(input logic [1:0] r, input logic [2:0] j);
    logic [63:0] row;
    case (r)
      2'd0:    row = 64'h01A4_5587_5A58_DB9E;
      2'd1:    row = 64'hA456_82F3_1EC6_68E5;
      2'd2:    row = 64'h02A1_FCC1_47AE_3D19;
      default: row = 64'hA455_875A_58DB_9E03;
    endcase
    return row[{~j, 3'b000} +: 8];
  endfunction

  // Next-state and control strobes
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce && start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (ce) begin
          step_c = 1'b1;
          if (j_q == 3'd7 && cnt_q == 2'(k_q - 3'd1)) begin
            last_c  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word index being accumulated, current key byte m_(8i+j), and updated accumulator
  always_comb begin
    widx_c     = REVERSE ? 2'(k_q - 3'd1 - {1'b0, cnt_q}) : cnt_q;
    byte_c     = key_q[{~{widx_c, j_q}, 3'b000} +: 8];
    acc_next_c = acc_q;
    for (int r = 0; r < 4; r++) begin
      acc_next_c[8*r +: 8] = acc_q[8*r +: 8] ^ gf_mul(rs_coef(2'(r), j_q), byte_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      s_valid  <= 1'b0;
      s_word   <= '0;
      s_idx    <= '0;
      keys_out <= '0;
      done     <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      done    <= 1'b0;
      if (accept_c) begin
        key_q    <= key;
        k_q      <= (key_len == 2'b01) ? 3'd3 : (key_len == 2'b10) ? 3'd4 : 3'd2;
        cnt_q    <= '0;
        j_q      <= '0;
        acc_q    <= '0;
        keys_out <= '0;
        busy     <= 1'b1;
      end else if (step_c) begin
        if (j_q == 3'd7) begin
          s_word                      <= acc_next_c;
          s_idx                       <= widx_c;
          s_valid                     <= 1'b1;
          keys_out[{cnt_q, 5'b0} +: 32] <= acc_next_c;
          acc_q                       <= '0;
          j_q                         <= '0;
          cnt_q                       <= cnt_q + 2'd1;
          if (last_c) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end else begin
          acc_q <= acc_next_c;
          j_q   <= j_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_skeygen_rs.sv
// Self-checking bench for skeygen_rs against a matrix-product reference model.
module tb_skeygen_rs;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ce = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key = '0;
  logic         busy, s_valid, done;
  logic [31:0]  s_word;
  logic [1:0]   s_idx;
  logic [127:0] keys_out;

  skeygen_rs #(.KEY_BITS(256)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .s_valid(s_valid), .s_word(s_word), .s_idx(s_idx),
    .keys_out(keys_out), .done(done)
  );

  always #5 clk = ~clk;

`ifdef SKEYGEN_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rs_tab [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  // reference model state
  logic [31:0]  exp_word [4];
  logic [1:0]   exp_idx  [4];
  int           exp_k;
  logic [127:0] exp_keys;

  // observations from one run
  logic [31:0]  got_word [4];
  logic [1:0]   got_idx  [4];
  int           got_at   [4];
  int           n_got, done_at;
  logic         busy_at_done, valid_at_done, busy_after_accept;
  bit           timed_out;

  // carry-less product then long-division by 0x14D
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int bt = 14; bt >= 8; bt--) if (p[bt]) p = p ^ (15'(9'h14D) << (bt - 8));
    return p[7:0];
  endfunction

  function automatic void model(input logic [255:0] kk, input logic [1:0] kl);
    int i;
    logic [31:0] w;
    logic [7:0] m;
    exp_k    = (kl == 2'b01) ? 3 : (kl == 2'b10) ? 4 : 2;
    exp_keys = '0;
    for (int p = 0; p < 4; p++) begin
      exp_word[p] = '0;
      exp_idx[p]  = '0;
    end
    for (int p = 0; p < exp_k; p++) begin
      i = REV ? exp_k - 1 - p : p;
      w = '0;
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 8; j++) begin
          m = kk[255 - 8*(8*i + j) -: 8];
          w[8*r +: 8] = w[8*r +: 8] ^ ref_mul(rs_tab[r][j], m);
        end
      exp_word[p] = w;
      exp_idx[p]  = 2'(i);
      exp_keys[32*p +: 32] = w;
    end
  endfunction

  // Launch one key and collect every strobe until done (bounded)
  task automatic do_run(input logic [255:0] kk, input logic [1:0] kl, input bit rand_ce,
                        input bit noise, input bit b2b);
    int en;
    if (!b2b) @(negedge clk);
    key = kk; key_len = kl; start = 1'b1; ce = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_after_accept = busy;
    en = 0; n_got = 0; done_at = -1; timed_out = 1'b1;
    busy_at_done = 1'b1; valid_at_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      ce = rand_ce ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (noise) begin
        key = {8{$urandom}};
        key_len = 2'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      if (ce) en++;
      if (s_valid) begin
        if (n_got < 4) begin
          got_word[n_got] = s_word;
          got_idx[n_got]  = s_idx;
          got_at[n_got]   = en;
        end
        n_got++;
      end
      if (done) begin
        done_at = en; busy_at_done = busy; valid_at_done = s_valid; timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; ce = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ce = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, s_valid, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {busy, s_valid, done}); end
    checks++; if (s_word !== 32'h0 || s_idx !== 2'd0) begin errors++; $display("FAIL reset_word got=%h/%0d want=0/0", s_word, s_idx); end
    checks++; if (keys_out !== 128'h0) begin errors++; $display("FAIL reset_keys got=%h want=0", keys_out); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [255:0] kk [7];
    logic [1:0]   kl [7];
    kk[0] = '0;          kl[0] = 2'b00;
    kk[1] = 256'h1 << 248; kl[1] = 2'b00;
    kk[2] = 256'h1 << 240; kl[2] = 2'b00;
    kk[3] = 256'h2 << 248; kl[3] = 2'b00;
    kk[4] = 256'h1 << 56;  kl[4] = 2'b10;
    kk[5] = 256'h1 << 120; kl[5] = 2'b01;
    kk[6] = {8{32'h1357_9BDF}}; kl[6] = 2'b11;
    for (int t = 0; t < 7; t++) begin
      model(kk[t], kl[t]);
      do_run(kk[t], kl[t], 1'b0, 1'b0, 1'b0);
      checks++; if (busy_after_accept !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=%b want=1", t, busy_after_accept); end
      checks++; if (timed_out || n_got != exp_k) begin errors++; $display("FAIL dir%0d_count got=%0d timeout=%0d want=%0d", t, n_got, timed_out, exp_k); end
      for (int p = 0; p < exp_k && p < n_got; p++) begin
        checks++; if (got_word[p] !== exp_word[p] || got_idx[p] !== exp_idx[p] || got_at[p] != 8*(p+1)) begin
          errors++; $display("FAIL dir%0d_word%0d got=%h/%0d@%0d want=%h/%0d@%0d", t, p, got_word[p], got_idx[p], got_at[p], exp_word[p], exp_idx[p], 8*(p+1));
        end
      end
      checks++; if (done_at != 8*exp_k || valid_at_done !== 1'b1 || busy_at_done !== 1'b0) begin
        errors++; $display("FAIL dir%0d_done got=@%0d v=%b b=%b want=@%0d v=1 b=0", t, done_at, valid_at_done, busy_at_done, 8*exp_k);
      end
      checks++; if (keys_out !== exp_keys) begin errors++; $display("FAIL dir%0d_keys got=%h want=%h", t, keys_out, exp_keys); end
    end
  endtask

  // Random keys with random ce stalls and input noise (start/key/key_len churn) while busy
  task automatic test_ce_stall();
    logic [255:0] kk;
    logic [1:0]   kl;
    for (int t = 0; t < 12; t++) begin
      kk = (t == 0) ? (256'h1 << 56) : {8{$urandom}};
      kl = (t == 0) ? 2'b10 : 2'($urandom);
      model(kk, kl);
      do_run(kk, kl, 1'b1, (t != 0), 1'b0);
      checks++; if (timed_out || n_got != exp_k) begin errors++; $display("FAIL stall%0d_count got=%0d timeout=%0d want=%0d", t, n_got, timed_out, exp_k); end
      for (int p = 0; p < exp_k && p < n_got; p++) begin
        checks++; if (got_word[p] !== exp_word[p] || got_idx[p] !== exp_idx[p] || got_at[p] != 8*(p+1)) begin
          errors++; $display("FAIL stall%0d_word%0d got=%h/%0d@%0d want=%h/%0d@%0d", t, p, got_word[p], got_idx[p], got_at[p], exp_word[p], exp_idx[p], 8*(p+1));
        end
      end
      checks++; if (done_at != 8*exp_k || busy_at_done !== 1'b0) begin errors++; $display("FAIL stall%0d_done got=@%0d b=%b want=@%0d b=0", t, done_at, busy_at_done, 8*exp_k); end
      checks++; if (keys_out !== exp_keys) begin errors++; $display("FAIL stall%0d_keys got=%h want=%h", t, keys_out, exp_keys); end
    end
  endtask

  // Next start issued in the very cycle done is high
  task automatic test_back_to_back();
    logic [255:0] kk;
    logic [1:0]   kl;
    do_run({8{$urandom}}, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      kk = {8{$urandom}};
      kl = 2'(t);
      model(kk, kl);
      do_run(kk, kl, 1'b0, 1'b0, 1'b1);
      checks++; if (busy_after_accept !== 1'b1) begin errors++; $display("FAIL b2b%0d_accept got=%b want=1", t, busy_after_accept); end
      checks++; if (timed_out || n_got != exp_k || done_at != 8*exp_k) begin errors++; $display("FAIL b2b%0d_count got=%0d@%0d want=%0d@%0d", t, n_got, done_at, exp_k, 8*exp_k); end
      for (int p = 0; p < exp_k && p < n_got; p++) begin
        checks++; if (got_word[p] !== exp_word[p] || got_idx[p] !== exp_idx[p]) begin
          errors++; $display("FAIL b2b%0d_word%0d got=%h/%0d want=%h/%0d", t, p, got_word[p], got_idx[p], exp_word[p], exp_idx[p]);
        end
      end
      checks++; if (keys_out !== exp_keys) begin errors++; $display("FAIL b2b%0d_keys got=%h want=%h", t, keys_out, exp_keys); end
    end
  endtask

  // Asynchronous reset at enabled cycle 11, then a fresh run
  task automatic test_reset_midrun();
    logic [255:0] kk;
    kk = {8{$urandom | 32'h0101_0101}};
    @(negedge clk);
    key = kk; key_len = 2'b10; start = 1'b1; ce = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%b want=1", busy); end
    reset = 1'b0;
    #1;
    checks++; if ({busy, s_valid, done} !== 3'b000) begin errors++; $display("FAIL midrun_flags got=%b want=000", {busy, s_valid, done}); end
    checks++; if (s_word !== 32'h0 || s_idx !== 2'd0 || keys_out !== 128'h0) begin
      errors++; $display("FAIL midrun_data got=%h/%0d/%h want=0", s_word, s_idx, keys_out);
    end
    @(negedge clk);
    reset = 1'b1;
    kk = {8{$urandom}};
    model(kk, 2'b10);
    do_run(kk, 2'b10, 1'b0, 1'b1, 1'b0);
    checks++; if (timed_out || n_got != exp_k || done_at != 8*exp_k) begin errors++; $display("FAIL postreset_count got=%0d@%0d want=%0d@%0d", n_got, done_at, exp_k, 8*exp_k); end
    for (int p = 0; p < exp_k && p < n_got; p++) begin
      checks++; if (got_word[p] !== exp_word[p] || got_idx[p] !== exp_idx[p]) begin
        errors++; $display("FAIL postreset_word%0d got=%h/%0d want=%h/%0d", p, got_word[p], got_idx[p], exp_word[p], exp_idx[p]);
      end
    end
    checks++; if (keys_out !== exp_keys) begin errors++; $display("FAIL postreset_keys got=%h want=%h", keys_out, exp_keys); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ce_stall();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
